hazard_predict_unit: RTL and testbench

- Second-generation pipeline hazard controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Adds a parametrised 2^IDX_W-entry branch history table of CTR_W-bit saturating counters that replaces static taken prediction.
- Adds an I/D memory-wait FSM, load-use stall detection, jump bubbles and saturating performance counters.
- Drives stall/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches.

---
 rtl/hazard_predict_unit.sv | 146 ++++++++++++++
 tb/tb_hazard_predict_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_predict_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core: BHT branch prediction,
// I/D memory-wait handling, load-use and jump bubbles, and performance counters.
module hazard_predict_unit #(
    parameter int IDX_W = 4,
    parameter int CTR_W = 2,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      if_pc,
    input  logic             if_is_branch,
    output logic             pred_taken,
    input  logic             ihit,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_is_jump,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             mem_valid,
    input  logic             mem_is_branch,
    input  logic             mem_taken,
    input  logic             mem_pred,
    input  logic [31:0]      mem_pc,
    input  logic             mem_dreq,
    input  logic             dhit,
    output logic             pc_stall,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             de_stall,
    output logic             de_flush,
    output logic             em_stall,
    output logic             em_flush,
    output logic             mw_flush,
    output logic             redirect,
    output logic [CNT_W-1:0] perf_mispred,
    output logic [CNT_W-1:0] perf_stall
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((2 ** (CTR_W - 1)) - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IWAIT = 2'd1,
        DWAIT = 2'd2
    } state_t;

    state_t           state;
    logic [CTR_W-1:0] bht [DEPTH];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] mem_idx;
    logic             mispred;
    logic             mispred_act;
    logic             dwait_act;
    logic             load_use;
    logic             fd_stall_req;
    logic             de_stall_req;
    logic             em_stall_req;
    logic             bht_upd;
    logic             unused_pc_bits;

    function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
        if (up)
            return (&c) ? c : c + CTR_W'(1);
        return (c == '0) ? c : c - CTR_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign if_idx  = if_pc[IDX_W+1:2];
    assign mem_idx = mem_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], mem_pc[31:IDX_W+2], mem_pc[1:0]};

    assign pred_taken = if_is_branch & bht[if_idx][CTR_W-1];

    // The data-side wait is held while the MEM access is outstanding, including its first cycle.
    assign dwait_act   = ((state == DWAIT) | mem_dreq) & ~dhit;
    assign mispred     = mem_valid & mem_is_branch & (mem_taken != mem_pred);
    assign mispred_act = mispred & ~dwait_act;
    assign load_use    = ex_is_load & (ex_rd != 5'd0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
    assign bht_upd     = mem_valid & mem_is_branch & ~em_stall;

    always_comb begin
        pc_stall     = 1'b0;
        fd_stall_req = 1'b0;
        fd_flush     = 1'b0;
        de_stall_req = 1'b0;
        de_flush     = 1'b0;
        em_stall_req = 1'b0;
        em_flush     = 1'b0;
        mw_flush     = 1'b0;
        redirect     = 1'b0;
        if (dwait_act) begin
            pc_stall     = 1'b1;
            fd_stall_req = 1'b1;
            de_stall_req = 1'b1;
            em_stall_req = 1'b1;
            mw_flush     = 1'b1;
        end else if (mispred) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
            redirect = 1'b1;
        end else if (load_use) begin
            pc_stall     = 1'b1;
            fd_stall_req = 1'b1;
            de_flush     = 1'b1;
        end else if (id_is_jump || !ihit) begin
            pc_stall = 1'b1;
            fd_flush = 1'b1;
        end
    end

    // A flush on a latch overrides a stall on the same latch.
    assign fd_stall = fd_stall_req & ~fd_flush;
    assign de_stall = de_stall_req & ~de_flush;
    assign em_stall = em_stall_req & ~em_flush;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= RUN;
            perf_mispred <= '0;
            perf_stall   <= '0;
            for (int i = 0; i < DEPTH; i++)
                bht[i] <= CTR_INIT;
        end else begin
            if (dwait_act)
                state <= DWAIT;
            else if (state != DWAIT && !ihit && !mispred_act)
                state <= IWAIT;
            else
                state <= RUN;

            if (bht_upd)
                bht[mem_idx] <= ctr_step(bht[mem_idx], mem_taken);
            if (mispred_act)
                perf_mispred <= cnt_sat_inc(perf_mispred);
            if (pc_stall)
                perf_stall <= cnt_sat_inc(perf_stall);
        end
    end

endmodule

// File: tb/tb_hazard_predict_unit.sv
// Bench for hazard_predict_unit: per-cycle expected control vectors go through a
// scoreboard queue; performance counters are checked at scenario ends.
module tb_hazard_predict_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] if_pc;
    logic        if_is_branch;
    logic        pred_taken;
    logic        ihit;
    logic [4:0]  id_rs, id_rt;
    logic        id_is_jump;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        mem_valid, mem_is_branch, mem_taken, mem_pred;
    logic [31:0] mem_pc;
    logic        mem_dreq, dhit;
    logic        pc_stall, fd_stall, fd_flush, de_stall, de_flush;
    logic        em_stall, em_flush, mw_flush, redirect;
    logic [31:0] perf_mispred, perf_stall;

    int n_chk  = 0;
    int n_pass = 0;
    logic [9:0] exp_q [$];

    // Vector layout: {pred, redirect, pc_s, fd_s, fd_f, de_s, de_f, em_s, em_f, mw_f}
    localparam logic [9:0] PRED  = 10'b10_0000_0000;
    localparam logic [9:0] REDIR = 10'b01_0000_0000;
    localparam logic [9:0] PCS   = 10'b00_1000_0000;
    localparam logic [9:0] FDS   = 10'b00_0100_0000;
    localparam logic [9:0] FDF   = 10'b00_0010_0000;
    localparam logic [9:0] DES   = 10'b00_0001_0000;
    localparam logic [9:0] DEF   = 10'b00_0000_1000;
    localparam logic [9:0] EMS   = 10'b00_0000_0100;
    localparam logic [9:0] EMF   = 10'b00_0000_0010;
    localparam logic [9:0] MWF   = 10'b00_0000_0001;
    localparam logic [9:0] E_MISP = REDIR | FDF | DEF | EMF;
    localparam logic [9:0] E_LU   = PCS | FDS | DEF;
    localparam logic [9:0] E_BUB  = PCS | FDF;
    localparam logic [9:0] E_DW   = PCS | FDS | DES | EMS | MWF;

    logic [9:0] obs;
    assign obs = {pred_taken, redirect, pc_stall, fd_stall, fd_flush,
                  de_stall, de_flush, em_stall, em_flush, mw_flush};

    hazard_predict_unit #(.IDX_W(4), .CTR_W(2), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .if_pc(if_pc), .if_is_branch(if_is_branch), .pred_taken(pred_taken),
        .ihit(ihit), .id_rs(id_rs), .id_rt(id_rt), .id_is_jump(id_is_jump),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_is_branch(mem_is_branch),
        .mem_taken(mem_taken), .mem_pred(mem_pred), .mem_pc(mem_pc),
        .mem_dreq(mem_dreq), .dhit(dhit),
        .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush),
        .de_stall(de_stall), .de_flush(de_flush), .em_stall(em_stall),
        .em_flush(em_flush), .mw_flush(mw_flush), .redirect(redirect),
        .perf_mispred(perf_mispred), .perf_stall(perf_stall)
    );

    always #5 CLK = ~CLK;

    task automatic idle();
        if_pc = 32'h0; if_is_branch = 1'b0; ihit = 1'b1;
        id_rs = 5'd0; id_rt = 5'd0; id_is_jump = 1'b0;
        ex_is_load = 1'b0; ex_rd = 5'd0;
        mem_valid = 1'b0; mem_is_branch = 1'b0; mem_taken = 1'b0; mem_pred = 1'b0;
        mem_pc = 32'h0; mem_dreq = 1'b0; dhit = 1'b1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk);
        mem_valid = 1'b1; mem_is_branch = 1'b1; mem_pc = pc;
        mem_taken = tk; mem_pred = tk;
    endtask

    task automatic misp(input logic tk);
        mem_valid = 1'b1; mem_is_branch = 1'b1; mem_pc = 32'h104;
        mem_taken = tk; mem_pred = ~tk;
    endtask

    task automatic fetch(input logic [31:0] pc);
        if_pc = pc; if_is_branch = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] e, got;
        for (int c = 0; c < 2; c++) begin
            idle();
            e = '0;
            if (c == 1) fetch(32'h40);
            exp_q.push_back(e);
            @(negedge CLK);
            got = obs; e = exp_q.pop_front();
            n_chk++;
            if (got !== e) $display("FAIL reset c%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            if (c == 0) begin
                n_chk++;
                if (perf_mispred !== 32'd0 || perf_stall !== 32'd0)
                    $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_mispred, perf_stall);
                else n_pass++;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_bht_counter();
        logic [9:0] e, got;
        for (int c = 0; c < 13; c++) begin
            idle();
            e = '0;
            if (c != 5) fetch(32'h40); else if_pc = 32'h40;
            case (c)
                1:  upd(32'h40, 1'b1);
                2:  begin upd(32'h40, 1'b1); e = PRED; end
                3:  begin upd(32'h40, 1'b1); e = PRED; end
                4:  e = PRED;
                6:  begin upd(32'h40, 1'b0); e = PRED; end
                7:  begin upd(32'h40, 1'b0); e = PRED; end
                9, 10: upd(32'h40, 1'b0);
                11: upd(32'h40, 1'b1);
                default: ;
            endcase
            exp_q.push_back(e);
            @(negedge CLK);
            got = obs; e = exp_q.pop_front();
            n_chk++;
            if (got !== e) $display("FAIL bht_counter c%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_alias_and_hold();
        logic [9:0] e, got;
        for (int c = 0; c < 9; c++) begin
            idle();
            e = '0;
            case (c)
                0, 1: upd(32'h40, 1'b1);
                2: begin fetch(32'h80); e = PRED; end
                3: fetch(32'h44);
                4: begin upd(32'h40, 1'b0); mem_dreq = 1'b1; dhit = 1'b0; e = E_DW; end
                5: begin upd(32'h40, 1'b0); mem_dreq = 1'b1; fetch(32'h40); e = PRED; end
                6: begin fetch(32'h40); e = PRED; end
                7: begin upd(32'h40, 1'b0); fetch(32'h80); e = PRED; end
                8: fetch(32'h80);
                default: ;
            endcase
            exp_q.push_back(e);
            @(negedge CLK);
            got = obs; e = exp_q.pop_front();
            n_chk++;
            if (got !== e) $display("FAIL alias_hold c%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_mispredict();
        logic [9:0] e, got;
        for (int c = 0; c < 9; c++) begin
            idle();
            e = '0;
            case (c)
                0: begin misp(1'b1); e = E_MISP; end
                2: upd(32'h104, 1'b1);
                3: upd(32'h104, 1'b0);
                4: begin misp(1'b0); e = E_MISP; end
                5: begin misp(1'b1); mem_valid = 1'b0; end
                6: begin misp(1'b1); ex_is_load = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
                         id_is_jump = 1'b1; e = E_MISP; end
                7: begin misp(1'b1); ihit = 1'b0; e = E_MISP; end
                default: ;
            endcase
            exp_q.push_back(e);
            @(negedge CLK);
            got = obs; e = exp_q.pop_front();
            n_chk++;
            if (got !== e) $display("FAIL mispredict c%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            if (c == 1) begin
                n_chk++;
                if (perf_mispred !== 32'd1) $display("FAIL perf_mispred_1 got=%0d exp=1", perf_mispred);
                else n_pass++;
            end
            if (c == 8) begin
                n_chk++;
                if (perf_mispred !== 32'd4 || perf_stall !== 32'd0)
                    $display("FAIL perf_after_misp got=%0d/%0d exp=4/0", perf_mispred, perf_stall);
                else n_pass++;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_load_use();
        logic [9:0] e, got;
        for (int c = 0; c < 9; c++) begin
            idle();
            e = '0;
            case (c)
                0: begin ex_is_load = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; e = E_LU; end
                2: begin ex_is_load = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; e = E_LU; end
                3: ex_is_load = 1'b1;
                4: begin ex_rd = 5'd8; id_rs = 5'd8; end
                5: begin ex_is_load = 1'b1; ex_rd = 5'd8; id_rs = 5'd9; id_rt = 5'd10; end
                6: begin ex_is_load = 1'b1; ex_rd = 5'd3; id_rt = 5'd3; id_is_jump = 1'b1; e = E_LU; end
                7: begin id_is_jump = 1'b1; e = E_BUB; end
                default: ;
            endcase
            exp_q.push_back(e);
            @(negedge CLK);
            got = obs; e = exp_q.pop_front();
            n_chk++;
            if (got !== e) $display("FAIL load_use c%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_dwait();
        logic [9:0] e, got;
        for (int c = 0; c < 5; c++) begin
            idle();
            e = '0;
            if (c < 4) mem_dreq = 1'b1;
            case (c)
                0: begin dhit = 1'b0; e = E_DW; end
                1: begin dhit = 1'b0; ex_is_load = 1'b1; ex_rd = 5'd8; id_rt = 5'd8; e = E_DW; end
                2: begin dhit = 1'b0; id_is_jump = 1'b1; ihit = 1'b0; e = E_DW; end
                default: ;
            endcase
            exp_q.push_back(e);
            @(negedge CLK);
            got = obs; e = exp_q.pop_front();
            n_chk++;
            if (got !== e) $display("FAIL dwait c%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            if (c == 4) begin
                n_chk++;
                if (perf_stall !== 32'd3) $display("FAIL perf_stall_dwait got=%0d exp=3", perf_stall);
                else n_pass++;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_iwait_redirect();
        logic [9:0] e, got;
        for (int c = 0; c < 5; c++) begin
            idle();
            e = '0;
            case (c)
                0: begin ihit = 1'b0; e = E_BUB; end
                1: begin ihit = 1'b0; misp(1'b1); e = E_MISP; end
                3: begin ihit = 1'b0; e = E_BUB; end
                default: ;
            endcase
            exp_q.push_back(e);
            @(negedge CLK);
            got = obs; e = exp_q.pop_front();
            n_chk++;
            if (got !== e) $display("FAIL iwait c%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            if (c == 4) begin
                n_chk++;
                if (perf_stall !== 32'd2 || perf_mispred !== 32'd1)
                    $display("FAIL perf_iwait got=%0d/%0d exp=2/1", perf_stall, perf_mispred);
                else n_pass++;
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid_dwait();
        logic [9:0] e, got;
        for (int c = 0; c < 9; c++) begin
            idle();
            e = '0;
            case (c)
                0, 1: upd(32'h40, 1'b1);
                2: begin misp(1'b1); e = E_MISP; end
                3: begin mem_dreq = 1'b1; dhit = 1'b0; e = E_DW; end
                4: begin RST = 1'b1; mem_dreq = 1'b1; dhit = 1'b0; e = E_DW; end
                5: begin RST = 1'b0; dhit = 1'b0; fetch(32'h40); end
                6: fetch(32'h44);
                7: upd(32'h40, 1'b1);
                8: begin fetch(32'h40); e = PRED; end
                default: ;
            endcase
            exp_q.push_back(e);
            @(negedge CLK);
            got = obs; e = exp_q.pop_front();
            n_chk++;
            if (got !== e) $display("FAIL reset_mid_dwait c%0d got=%b exp=%b", c, got, e);
            else n_pass++;
            if (c == 5) begin
                n_chk++;
                if (perf_mispred !== 32'd0 || perf_stall !== 32'd0)
                    $display("FAIL perf_after_rst got=%0d/%0d exp=0/0", perf_mispred, perf_stall);
                else n_pass++;
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        idle();
        do_reset();
        test_reset();
        do_reset();
        test_bht_counter();
        do_reset();
        test_alias_and_hold();
        do_reset();
        test_mispredict();
        do_reset();
        test_load_use();
        do_reset();
        test_dwait();
        do_reset();
        test_iwait_redirect();
        do_reset();
        test_reset_mid_dwait();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
